// File: rtl/srl_stream_ctrl.sv
// srl_stream_ctrl: wraps an external REG_NUM-deep static shift register
// (shared clock enable, I/Q data bus) as a valid/ready stream stage with a
// fixed delay of REG_NUM shifts. A shadow validity vector follows every shift
// so empty slots and stale SRL contents are never presented downstream.
// A flush drains all valid words by pushing zero words into the SRL.
module srl_stream_ctrl #(
  parameter  int DATA_WIDTH = 16,
  parameter  int REG_NUM    = 32,
  localparam int BUS_W      = 2 * DATA_WIDTH,
  localparam int OCC_W      = $clog2(REG_NUM + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BUS_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BUS_W-1:0] out_data,
  output logic             srl_ce,
  output logic [BUS_W-1:0] srl_din,
  input  logic [BUS_W-1:0] srl_dout,
  output logic [OCC_W-1:0] occupancy,
  output logic             busy,
  output logic             flush_done
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [OCC_W-1:0] OCC_ZERO = {OCC_W{1'b0}};
  localparam logic [OCC_W-1:0] OCC_ONE  = {{(OCC_W-1){1'b0}}, 1'b1};
  localparam logic [BUS_W-1:0] BUS_ZERO = {BUS_W{1'b0}};

  state_e             state_q;
  logic               busy_q;
  logic               flush_done_q;

  logic [REG_NUM-1:0] vld_q;
  logic [REG_NUM-1:0] vld_d;
  logic [OCC_W-1:0]   occ_q;
  logic [OCC_W-1:0]   occ_d;
  logic               out_valid_q;
  logic               out_valid_d;
  logic [BUS_W-1:0]   out_data_q;
  logic [BUS_W-1:0]   out_data_d;

  // Combinational stream-control signals.
  logic               exit_v;
  logic               can_shift;
  logic               occ_nz;
  logic               ready_c;
  logic               ce_c;
  logic [BUS_W-1:0]   din_c;
  logic               shift_in_valid;
  logic               word_in;
  logic               word_out;

  // Decide whether the SRL shifts this cycle and what enters slot 0.
  always_comb begin
    exit_v         = vld_q[REG_NUM-1];
    // A valid word sitting at the exit may only move once the output
    // register is free or being consumed in this same cycle.
    can_shift      = ~exit_v | ~out_valid_q | out_ready;
    occ_nz         = (occ_q != OCC_ZERO);
    ready_c        = 1'b0;
    ce_c           = 1'b0;
    din_c          = BUS_ZERO;
    shift_in_valid = 1'b0;
    if (rst) begin
      ready_c        = 1'b0;
      ce_c           = 1'b0;
      din_c          = BUS_ZERO;
      shift_in_valid = 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          ready_c        = can_shift;
          ce_c           = in_valid & can_shift;
          din_c          = in_data;
          shift_in_valid = 1'b1;
        end
        ST_DRAIN: begin
          // Zero words push the remaining valid words toward the exit.
          ready_c        = 1'b0;
          ce_c           = can_shift & occ_nz;
          din_c          = BUS_ZERO;
          shift_in_valid = 1'b0;
        end
        ST_DONE: begin
          ready_c        = 1'b0;
          ce_c           = 1'b0;
          din_c          = BUS_ZERO;
          shift_in_valid = 1'b0;
        end
        default: begin
          ready_c        = 1'b0;
          ce_c           = 1'b0;
          din_c          = BUS_ZERO;
          shift_in_valid = 1'b0;
        end
      endcase
    end
  end

  assign in_ready = ready_c;
  assign srl_ce   = ce_c;
  assign srl_din  = din_c;

  // Next state of the validity shadow, occupancy and output register.
  always_comb begin
    word_in     = ce_c & shift_in_valid;
    word_out    = ce_c & exit_v;
    vld_d       = vld_q;
    occ_d       = occ_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (ce_c) begin
      vld_d = {vld_q[REG_NUM-2:0], shift_in_valid};
    end else begin
      vld_d = vld_q;
    end

    case ({word_in, word_out})
      2'b10:   occ_d = occ_q + OCC_ONE;
      2'b01:   occ_d = occ_q - OCC_ONE;
      default: occ_d = occ_q;
    endcase

    // The oldest slot is captured only when a valid word actually exits.
    if (word_out) begin
      out_data_d  = srl_dout;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_data_d  = out_data_q;
      out_valid_d = 1'b0;
    end else begin
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
    end
  end

  // Flush sequencer: RUN -> DRAIN -> DONE -> RUN, with registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      busy_q       <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (flush) begin
            state_q <= ST_DRAIN;
            busy_q  <= 1'b1;
          end else begin
            state_q <= ST_RUN;
            busy_q  <= 1'b0;
          end
          flush_done_q <= 1'b0;
        end
        ST_DRAIN: begin
          // An empty SRL means no shift can be pending; flush is ignored here.
          if (!occ_nz) begin
            state_q      <= ST_DONE;
            busy_q       <= 1'b0;
            flush_done_q <= 1'b1;
          end else begin
            state_q      <= ST_DRAIN;
            busy_q       <= 1'b1;
            flush_done_q <= 1'b0;
          end
        end
        ST_DONE: begin
          state_q      <= ST_RUN;
          busy_q       <= 1'b0;
          flush_done_q <= 1'b0;
        end
        default: begin
          state_q      <= ST_RUN;
          busy_q       <= 1'b0;
          flush_done_q <= 1'b0;
        end
      endcase
    end
  end

  // Datapath state; SRL data itself has no reset, so clearing vld masks it.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q       <= {REG_NUM{1'b0}};
      occ_q       <= OCC_ZERO;
      out_valid_q <= 1'b0;
      out_data_q  <= BUS_ZERO;
    end else begin
      vld_q       <= vld_d;
      occ_q       <= occ_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign occupancy  = occ_q;
  assign busy       = busy_q;
  assign flush_done = flush_done_q;

endmodule
